// File: rtl/stm_rr.sv
// stm_rr: round-robin phase sequencer over a WIDTH-bit state register r.
// Each enabled edge applies the current phase's external function result
// (ext_res slice[phase]) to r and moves on to the next unmasked phase.
// A phase whose skip_mask bit is set is passed over without touching r.
//
// Optional feature: define STM_RR_ROUND_COUNT_EN to get a saturating 16-bit
// completed-round counter on `rounds`; otherwise `rounds` is tied to zero.
//
//   condition                   | effect at the edge
//   RST                         | r=0, phase=0, wrap=0, rounds=0
//   skip_mask all ones          | hold r and phase, wrap=0
//   en=0                        | hold r and phase, wrap=0
//   en=1, skip_mask[phase]=0    | r <= slice[phase], phase <= nxt
//   en=1, skip_mask[phase]=1    | hold r, phase <= nxt
module stm_rr #(
  parameter int WIDTH   = 32,
  parameter int NPHASES = 4,
  parameter int PHASE_W = 2
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       en,
  input  logic [NPHASES-1:0]         skip_mask,
  input  logic [WIDTH-1:0]           inputs,
  output logic [WIDTH-1:0]           ext_r,
  input  logic [NPHASES*WIDTH-1:0]   ext_res,
  output logic [PHASE_W-1:0]         phase,
  output logic [WIDTH-1:0]           outputs,
  output logic                       wrap,
  output logic [15:0]                rounds
);

  // Phase arithmetic is done one bit wider so phase+k never overflows.
  localparam logic [PHASE_W:0] NP_EXT = NPHASES[PHASE_W:0];

  logic [WIDTH-1:0]   r;
  logic [WIDTH-1:0]   cur_res;
  logic [PHASE_W-1:0] nxt;
  logic [PHASE_W:0]   cand;
  logic               found;
  logic               all_skip;
  logic               adv;
  logic               wrap_set;

  // `inputs` only feeds the external phase functions; nothing inside uses it.
  logic unused_inputs;
  assign unused_inputs = ^inputs;

  assign ext_r    = r;
  assign outputs  = r;
  assign all_skip = &skip_mask;
  assign adv      = en & ~all_skip;
  // Wrap-around (including a lone active phase mapping onto itself) closes a round.
  assign wrap_set = adv & (nxt <= phase);

  // Select the external function result belonging to the current phase.
  always_comb begin
    cur_res = '0;
    for (int i = 0; i < NPHASES; i++) begin
      if (phase == i[PHASE_W-1:0]) cur_res = ext_res[i*WIDTH +: WIDTH];
    end
  end

  // Find the first unmasked phase after the current one, searching cyclically.
  always_comb begin
    nxt   = phase;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NPHASES; k++) begin
      cand = {1'b0, phase} + k[PHASE_W:0];
      if (cand >= NP_EXT) cand = cand - NP_EXT;
      if (!found && !skip_mask[cand[PHASE_W-1:0]]) begin
        nxt   = cand[PHASE_W-1:0];
        found = 1'b1;
      end
    end
  end

  // State register, phase pointer and end-of-round pulse.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r     <= '0;
      phase <= '0;
      wrap  <= 1'b0;
    end else begin
      wrap <= wrap_set;
      if (adv) begin
        if (!skip_mask[phase]) r <= cur_res;
        phase <= nxt;
      end
    end
  end

`ifdef STM_RR_ROUND_COUNT_EN
  logic [15:0] round_cnt;

  // Saturating count of completed rounds.
  always_ff @(posedge CLK) begin
    if (RST) begin
      round_cnt <= '0;
    end else if (wrap_set && (round_cnt != 16'hFFFF)) begin
      round_cnt <= round_cnt + 16'd1;
    end
  end

  assign rounds = round_cnt;
`else
  assign rounds = 16'h0000;
`endif

endmodule

// File: doc/stm_rr.md
STM_RR -- requirements
Module: stm_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath width of state register r (>=1).
REQ-002 SHALL have parameter NPHASES, default 4, meaning number of round-robin phases (>=2).
REQ-003 SHALL have parameter PHASE_W, default 2, meaning phase index width; 2**PHASE_W >= NPHASES is required.
REQ-004 SHALL have port CLK  in  1  rising-edge clock.
REQ-005 SHALL have port RST  in  1  synchronous active-high reset.
REQ-006 SHALL have port en  in  1  advance enable; when low the block holds all state.
REQ-007 SHALL have port skip_mask  in  NPHASES  bit i set means phase i is skipped.
REQ-008 SHALL have port inputs  in  WIDTH  external data operand passed to the phase functions.
REQ-009 SHALL have port ext_r  out  WIDTH  current r, the operand for the external phase functions.
REQ-010 SHALL have port ext_res  in  NPHASES*WIDTH  slice [i*WIDTH +: WIDTH] is f_i(ext_r, inputs), computed combinationally outside the block.
REQ-011 SHALL have port phase  out  PHASE_W  current phase index.
REQ-012 SHALL have port outputs  out  WIDTH  equal to r.
REQ-013 SHALL have port wrap  out  1  registered one-cycle pulse marking the end of a round.
REQ-014 SHALL have port rounds  out  16  completed-round count (see REQ-028).

Function
REQ-015 SHALL drive outputs and ext_r combinationally from r, with zero latency.
REQ-016 SHALL define nxt as the first index (phase+k) mod NPHASES, for k=1..NPHASES, whose skip_mask bit is clear; k=NPHASES yields phase itself.
REQ-017 SHALL, on an edge with en=1 and the skip_mask bit of phase clear, load r <= ext_res slice[phase] and set phase <= nxt.
REQ-018 SHALL, on an edge with en=1 and the skip_mask bit of phase set, hold r and set phase <= nxt; this covers a mask changed mid-round.
REQ-019 SHALL, when skip_mask is all ones, hold r and phase regardless of en, and hold wrap low.
REQ-020 SHALL, on an edge with en=0, hold r and phase and set wrap <= 0.
REQ-021 SHALL set wrap <= 1 on an edge where the phase register is written and nxt <= phase (index wrap-around, including a single active phase); otherwise wrap <= 0.
REQ-022 SHALL sample skip_mask combinationally each cycle, so a mask change takes effect at the next edge.
REQ-023 SHALL never let phase hold a value >= NPHASES.
REQ-024 SHALL, for NPHASES=2 with skip_mask=0, reduce to plain alternation: phase 0,1,0,1, with r taking slice 0 then slice 1.

Reset
REQ-025 SHALL, on an edge with RST=1, set r=0, phase=0, wrap=0 and rounds=0; RST has priority over en.
REQ-026 SHALL, after reset, start at phase 0 even if skip_mask[0] is set; the first enabled edge then applies REQ-018.
REQ-027 SHALL, on reset asserted mid-round, discard the round in progress without a wrap pulse.

Configuration
REQ-028 SHALL, with macro STM_RR_ROUND_COUNT_EN defined, keep a 16-bit rounds counter that increments on every edge setting wrap <= 1 and saturates at 0xFFFF.
REQ-029 SHALL, without STM_RR_ROUND_COUNT_EN, keep the rounds port present and tie it to constant 0, with no counter logic.

Verification
REQ-030 SHALL cover: defaults, ext_res slice i = 0x1000_0000+i, mask=0, en=1 for 8 cycles after reset -> phase 0,1,2,3,0,1,2,3; r 0,0x10000000,..1,..2,..3,..0; wrap high the cycle after each 3->0.
REQ-031 SHALL cover: mask=4'b1010 -> phase 0,2,0,2; r takes slices 0 and 2 only; wrap after each 2->0.
REQ-032 SHALL cover: en low for 3 cycles mid-round at phase 2 -> phase, r and rounds frozen and wrap=0; resume continues at phase 2.
REQ-033 SHALL cover: mask=4'b1111 with en=1 -> r and phase hold indefinitely; then mask=4'b1110 -> phase goes to 0 and wrap pulses every enabled edge.
REQ-034 SHALL cover: RST=1 with en=1 at phase 3 -> next cycle phase=0, r=0, wrap=0, rounds=0.
REQ-035 SHALL cover: with STM_RR_ROUND_COUNT_EN, 3 full rounds -> rounds=3; force saturation with 65540 rounds -> rounds=0xFFFF; without the macro -> rounds=0 always.
